// File: rtl/nand_bist_pkg.sv
// Shared types and reference function for the NAND I/O BIST engine.
package nand_bist_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} bist_state_t;

  // Widest operand the reference function handles; callers cast down to their width.
  localparam int unsigned NAND_REF_W = 16;

  // Golden bit-wise NAND result.
  function automatic logic [NAND_REF_W-1:0] nand_ref(input logic [NAND_REF_W-1:0] a,
                                                     input logic [NAND_REF_W-1:0] b);
    return ~(a & b);
  endfunction

endpackage

// File: rtl/nand_bist_vecgen.sv
// Vector generator: ascending operand-pair counter split into stim_a (low half) and stim_b (high half).
module nand_bist_vecgen #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             step,
  output logic [WIDTH-1:0] stim_a,
  output logic [WIDTH-1:0] stim_b,
  output logic             last_c
);

  localparam int unsigned VEC_W = 2 * WIDTH;

  logic [VEC_W-1:0] v;

  // Vector index: cleared on sweep start, advanced after each check.
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
    end else if (clear) begin
      v <= '0;
    end else if (step) begin
      v <= v + VEC_W'(1);
    end
  end

  assign stim_a = v[WIDTH-1:0];
  assign stim_b = v[VEC_W-1:WIDTH];
  assign last_c = (v == {VEC_W{1'b1}});

endmodule

// File: rtl/nand_io_bist.sv
// NAND I/O BIST: sweeps every operand pair, waits SETTLE_CYC cycles per vector,
// compares resp with ~(a & b) and counts mismatches (saturating).
// Optional macro BIST_FIRST_FAIL_EN adds first-failure capture (fail_valid/fail_vec/fail_resp).
module nand_io_bist
  import nand_bist_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned ERR_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   stim_a,
  output logic [WIDTH-1:0]   stim_b,
  input  logic [WIDTH-1:0]   resp,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count
`ifdef BIST_FIRST_FAIL_EN
  ,
  output logic               fail_valid,
  output logic [2*WIDTH-1:0] fail_vec,
  output logic [WIDTH-1:0]   fail_resp
`endif
);

  localparam int unsigned CNT_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);

  bist_state_t       state;
  logic [CNT_W-1:0]  settle_cnt;
  logic              load_c;
  logic              step_c;
  logic              last_c;
  logic [WIDTH-1:0]  expect_c;
  logic              mismatch_c;
  logic [ERR_W-1:0]  err_next_c;

  assign load_c     = start && ((state == IDLE) || (state == DONE));
  assign step_c     = (state == CHECK) && !last_c;
  assign expect_c   = WIDTH'(nand_ref(NAND_REF_W'(stim_a), NAND_REF_W'(stim_b)));
  assign mismatch_c = (resp != expect_c);
  assign err_next_c = (mismatch_c && (err_count != {ERR_W{1'b1}})) ? err_count + ERR_W'(1)
                                                                   : err_count;

  nand_bist_vecgen #(
    .WIDTH (WIDTH)
  ) u_vecgen (
    .clk    (clk),
    .rst    (rst),
    .clear  (load_c),
    .step   (step_c),
    .stim_a (stim_a),
    .stim_b (stim_b),
    .last_c (last_c)
  );

  // Sweep sequencer with settle counter, error accumulation and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
`ifdef BIST_FIRST_FAIL_EN
      fail_valid <= 1'b0;
      fail_vec   <= '0;
      fail_resp  <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
`ifdef BIST_FIRST_FAIL_EN
            fail_valid <= 1'b0;
            fail_vec   <= '0;
            fail_resp  <= '0;
`endif
          end
        end
        SETTLE: begin
          if (settle_cnt == CNT_W'(SETTLE_CYC - 1)) begin
            state      <= CHECK;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end
        CHECK: begin
          err_count <= err_next_c;
`ifdef BIST_FIRST_FAIL_EN
          if (mismatch_c && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_vec   <= {stim_b, stim_a};
            fail_resp  <= resp;
          end
`endif
          if (last_c) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next_c == '0);
          end else begin
            state <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nand_io_bist.sv
// Scoreboard bench for nand_io_bist (WIDTH=2, SETTLE_CYC=2; ERR_W=4 main, ERR_W=3 saturation instance).
module tb_nand_io_bist;

  localparam int unsigned W   = 2;
  localparam int unsigned LAT = 48;

  typedef struct {
    int err;
    int pass;
    int fvalid;
    int fvec;
    int fresp;
    int start_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         start_s;
  logic [W-1:0] stim_a, stim_b, resp;
  logic         busy, done, pass;
  logic [3:0]   err_count;
  logic [W-1:0] stim_a_s, stim_b_s;
  logic         busy_s, done_s, pass_s;
  logic [2:0]   err_count_s;
`ifdef BIST_FIRST_FAIL_EN
  logic         fail_valid, fail_valid_s;
  logic [2*W-1:0] fail_vec, fail_vec_s;
  logic [W-1:0] fail_resp, fail_resp_s;
`endif

  int   mode;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  exp_t exp_sq[$];
  logic done_prev = 1'b0;
  logic done_s_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Response model: 0 ideal, 1 stuck at 0, 2 fault injected on v=9 only.
  always_comb begin
    resp = ~(stim_a & stim_b);
    if (mode == 1) resp = '0;
    else if (mode == 2 && stim_a == 2'd1 && stim_b == 2'd2) resp = ~(~(stim_a & stim_b));
  end

  nand_io_bist #(.WIDTH(W), .SETTLE_CYC(2), .ERR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stim_a(stim_a), .stim_b(stim_b), .resp(resp),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count)
`ifdef BIST_FIRST_FAIL_EN
    , .fail_valid(fail_valid), .fail_vec(fail_vec), .fail_resp(fail_resp)
`endif
  );

  nand_io_bist #(.WIDTH(W), .SETTLE_CYC(2), .ERR_W(3)) dut_sat (
    .clk(clk), .rst(rst), .start(start_s), .stim_a(stim_a_s), .stim_b(stim_b_s), .resp(2'b01),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_count_s)
`ifdef BIST_FIRST_FAIL_EN
    , .fail_valid(fail_valid_s), .fail_vec(fail_vec_s), .fail_resp(fail_resp_s)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Main-instance monitor: compares each completed sweep against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done && !done_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("latency", cyc - e.start_cyc, LAT);
        check("err_count", int'(err_count), e.err);
        check("pass", int'(pass), e.pass);
        check("busy_at_done", int'(busy), 0);
`ifdef BIST_FIRST_FAIL_EN
        check("fail_valid", int'(fail_valid), e.fvalid);
        if (e.fvalid != 0) begin
          check("fail_vec", int'(fail_vec), e.fvec);
          check("fail_resp", int'(fail_resp), e.fresp);
        end
`endif
      end
    end
    done_prev = done;
  end

  // Saturation-instance monitor.
  always @(negedge clk) begin
    exp_t e;
    if (done_s && !done_s_prev) begin
      if (exp_sq.size() == 0) begin
        check("sat_unexpected_done", 1, 0);
      end else begin
        e = exp_sq.pop_front();
        check("sat_latency", cyc - e.start_cyc, LAT);
        check("sat_err_count", int'(err_count_s), e.err);
        check("sat_pass", int'(pass_s), e.pass);
`ifdef BIST_FIRST_FAIL_EN
        check("sat_fail_vec", int'(fail_vec_s), e.fvec);
        check("sat_fail_resp", int'(fail_resp_s), e.fresp);
`endif
      end
    end
    done_s_prev = done_s;
  end

  task automatic pulse_start(input exp_t e);
    exp_t x;
    @(negedge clk);
    x = e;
    x.start_cyc = cyc + 1;
    exp_q.push_back(x);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_timeout", int'(seen), 1);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; start = 1'b0; start_s = 1'b0; mode = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_err", int'(err_count), 0);
    check("rst_stim", int'({stim_b, stim_a}), 0);

    // Saturating counter: resp stuck at 01 mismatches 13 of 16 vectors, capped at 7.
    @(negedge clk);
    e = '{err: 7, pass: 0, fvalid: 1, fvec: 0, fresp: 1, start_cyc: cyc + 1};
    exp_sq.push_back(e);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;

    // Ideal model.
    mode = 0;
    pulse_start('{err: 0, pass: 1, fvalid: 0, fvec: 0, fresp: 0, start_cyc: 0});
    check("t1_busy", int'(busy), 1);
    check("t1_stim0", int'({stim_b, stim_a}), 0);
    wait_done();

    // Stuck-at-0 response, started from DONE.
    mode = 1;
    pulse_start('{err: 15, pass: 0, fvalid: 1, fvec: 0, fresp: 0, start_cyc: 0});
    check("t2_done_clr", int'(done), 0);
    check("t2_err_clr", int'(err_count), 0);
    check("t2_busy", int'(busy), 1);
    wait_done();
    check("t2_hold_stim", int'({stim_b, stim_a}), 15);

    // Start while busy is ignored.
    mode = 0;
    pulse_start('{err: 0, pass: 1, fvalid: 0, fvec: 0, fresp: 0, start_cyc: 0});
`ifdef BIST_FIRST_FAIL_EN
    check("t4_fail_clr", int'(fail_valid), 0);
`endif
    repeat (18) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t4_busy_kept", int'(busy), 1);
    wait_done();

    // Single fault at v=9.
    mode = 2;
    pulse_start('{err: 1, pass: 0, fvalid: 1, fvec: 9, fresp: 0, start_cyc: 0});
    wait_done();

    // Reset mid-sweep.
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy", int'(busy), 0);
    check("t5_done", int'(done), 0);
    check("t5_stim", int'({stim_b, stim_a}), 0);
    check("t5_err", int'(err_count), 0);

    // start and rst together: stays idle.
    start = 1'b1; rst = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    check("t5_sr_busy", int'(busy), 0);
    repeat (4) @(negedge clk);
    check("t5_sr_idle", int'(busy), 0);
    check("t5_sr_stim", int'({stim_b, stim_a}), 0);

    check("exp_q_drained", exp_q.size(), 0);
    check("exp_sq_drained", exp_sq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard time limit.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
